// File: rtl/fault_fsm_pkg.sv
// -----------------------------------------------------------------------------
// fault_fsm_pkg
//   Shared types for the power-stage fault supervisor.
//   - state_e    : supervisor state encoding (NORMAL, WARNING, FAULT, SHUTDOWN)
//   - fault_id_e : dominant-fault identifiers reported on active_fault_id
//   Optional feature macro used by the supervisor: FAULT_FSM_AUTO_RECOVER_EN
// -----------------------------------------------------------------------------
package fault_fsm_pkg;

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        WARNING  = 2'd1,
        FAULT    = 2'd2,
        SHUTDOWN = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        ID_NONE = 3'd0,
        ID_UV   = 3'd1,
        ID_OV   = 3'd2,
        ID_OT   = 3'd3,
        ID_UC   = 3'd4
    } fault_id_e;

endpackage : fault_fsm_pkg

// File: rtl/fault_fsm_if.sv
// -----------------------------------------------------------------------------
// fault_fsm_if
//   Bundle of all non-clock signals of the fault supervisor.
//   Parameter CNT_W : width of each persistence counter.
//   master modport (comparator/control side):
//     drives  ov, uv, ot, uc, mask_ov/uv/ot/uc, clear_warning
//     reads   state, warn, fault, shutdown, active_fault_id, cnt_uv/ov/ot/uc
//   slave modport (supervisor side): the mirror image.
// -----------------------------------------------------------------------------
interface fault_fsm_if #(
    parameter int CNT_W = 8
);
    import fault_fsm_pkg::*;

    // Raw comparator flags and per-channel masks (1 = ignore channel)
    logic ov;
    logic uv;
    logic ot;
    logic uc;
    logic mask_ov;
    logic mask_uv;
    logic mask_ot;
    logic mask_uc;
    logic clear_warning;

    // Status / telemetry
    state_e            state;
    logic              warn;
    logic              fault;
    logic              shutdown;
    fault_id_e         active_fault_id;
    logic [CNT_W-1:0]  cnt_uv;
    logic [CNT_W-1:0]  cnt_ov;
    logic [CNT_W-1:0]  cnt_ot;
    logic [CNT_W-1:0]  cnt_uc;

    modport master (
        output ov, uv, ot, uc,
        output mask_ov, mask_uv, mask_ot, mask_uc,
        output clear_warning,
        input  state, warn, fault, shutdown, active_fault_id,
        input  cnt_uv, cnt_ov, cnt_ot, cnt_uc
    );

    modport slave (
        input  ov, uv, ot, uc,
        input  mask_ov, mask_uv, mask_ot, mask_uc,
        input  clear_warning,
        output state, warn, fault, shutdown, active_fault_id,
        output cnt_uv, cnt_ov, cnt_ot, cnt_uc
    );

endinterface : fault_fsm_if

// File: rtl/fault_debounce.sv
// -----------------------------------------------------------------------------
// fault_debounce
//   One persistence counter. Counts consecutive clock edges on which the
//   (already masked) fault flag is high, saturating at all-ones, and clears
//   to zero on the first edge the flag is low.
//   Ports:
//     clk   in  1      clock, rising edge
//     rst   in  1      synchronous active-high reset
//     flag  in  1      effective (masked) fault flag
//     cnt   out CNT_W  persistence count
// -----------------------------------------------------------------------------
module fault_debounce #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flag,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!flag) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule : fault_debounce

// File: rtl/fault_fsm.sv
// -----------------------------------------------------------------------------
// fault_fsm
//   Power-stage fault supervisor. Debounces OV/UV/OT/UC with persistence
//   counters and escalates NORMAL -> WARNING -> FAULT -> SHUTDOWN.
//   Ports:
//     clk   in  1   clock, rising edge
//     rst   in  1   synchronous active-high reset
//     bus   fault_fsm_if.slave : flags, masks, clear_warning in;
//                                state, warn/fault/shutdown, active_fault_id,
//                                cnt_uv/ov/ot/uc out
//   Parameters: CNT_W, WARN_TH, FAULT_TH, SHUTDOWN_TH
//     (legal only if 0 < WARN_TH < FAULT_TH < SHUTDOWN_TH <= 2**CNT_W-1)
//   Optional feature: define FAULT_FSM_AUTO_RECOVER_EN to let WARNING fall
//   back to NORMAL without clear_warning once every counter is zero.
// -----------------------------------------------------------------------------
module fault_fsm
    import fault_fsm_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int WARN_TH     = 4,
    parameter int FAULT_TH    = 16,
    parameter int SHUTDOWN_TH = 32
) (
    input logic        clk,
    input logic        rst,
    fault_fsm_if.slave bus
);

    localparam logic [CNT_W-1:0] WARN_C     = CNT_W'(WARN_TH);
    localparam logic [CNT_W-1:0] FAULT_C    = CNT_W'(FAULT_TH);
    localparam logic [CNT_W-1:0] SHUTDOWN_C = CNT_W'(SHUTDOWN_TH);

    // ---------------------------------------------------------------- counters
    logic eff_uv, eff_ov, eff_ot, eff_uc;
    logic [CNT_W-1:0] cnt_uv, cnt_ov, cnt_ot, cnt_uc;

    assign eff_uv = bus.uv & ~bus.mask_uv;
    assign eff_ov = bus.ov & ~bus.mask_ov;
    assign eff_ot = bus.ot & ~bus.mask_ot;
    assign eff_uc = bus.uc & ~bus.mask_uc;

    fault_debounce #(.CNT_W(CNT_W)) u_deb_uv (.clk(clk), .rst(rst), .flag(eff_uv), .cnt(cnt_uv));
    fault_debounce #(.CNT_W(CNT_W)) u_deb_ov (.clk(clk), .rst(rst), .flag(eff_ov), .cnt(cnt_ov));
    fault_debounce #(.CNT_W(CNT_W)) u_deb_ot (.clk(clk), .rst(rst), .flag(eff_ot), .cnt(cnt_ot));
    fault_debounce #(.CNT_W(CNT_W)) u_deb_uc (.clk(clk), .rst(rst), .flag(eff_uc), .cnt(cnt_uc));

    // ------------------------------------------------------ dominant channel
    logic [CNT_W-1:0] max_cnt;
    fault_id_e        dom_id;

    // Channels are visited in tie-priority order (OT, OV, UV, UC); a later
    // channel only takes over on a strictly larger count, so ties keep the
    // higher-priority channel.
    // NOTE: blocking assignments are right here: each comparison must see
    // the max_cnt already updated by the previous one.
    always_comb begin
        max_cnt = cnt_ot;
        dom_id  = ID_OT;
        if (cnt_ov > max_cnt) begin
            max_cnt = cnt_ov;
            dom_id  = ID_OV;
        end
        if (cnt_uv > max_cnt) begin
            max_cnt = cnt_uv;
            dom_id  = ID_UV;
        end
        if (cnt_uc > max_cnt) begin
            max_cnt = cnt_uc;
            dom_id  = ID_UC;
        end
        if (max_cnt == '0) begin
            dom_id = ID_NONE;
        end
    end

    // ----------------------------------------------------------- state machine
    state_e    state_q, state_d;
    fault_id_e id_q, id_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= NORMAL;
            id_q    <= ID_NONE;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    // Escalation is tested first in every state so it wins over an operator
    // acknowledge arriving in the same cycle; each state only steps to its
    // neighbour, so NORMAL can never reach FAULT in one edge.
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        unique case (state_q)
            NORMAL: begin
                if (max_cnt >= WARN_C) begin
                    state_d = WARNING;
                    id_d    = dom_id;
                end
            end
            WARNING: begin
                if (max_cnt >= FAULT_C) begin
                    state_d = FAULT;
                    id_d    = dom_id;
                end else if (bus.clear_warning && (max_cnt < WARN_C)) begin
                    state_d = NORMAL;
                    id_d    = ID_NONE;
                end
`ifdef FAULT_FSM_AUTO_RECOVER_EN
                else if (max_cnt == '0) begin
                    state_d = NORMAL;
                    id_d    = ID_NONE;
                end
`else
                else begin
                    state_d = WARNING;
                end
`endif
            end
            FAULT: begin
                if (max_cnt >= SHUTDOWN_C) begin
                    state_d = SHUTDOWN;
                    id_d    = dom_id;
                end else if (bus.clear_warning && (max_cnt == '0)) begin
                    state_d = NORMAL;
                    id_d    = ID_NONE;
                end
            end
            SHUTDOWN: begin
                // Latched until rst; active_fault_id stays frozen.
                state_d = SHUTDOWN;
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // ---------------------------------------------------------------- outputs
    assign bus.state           = state_q;
    assign bus.warn            = (state_q == WARNING);
    assign bus.fault           = (state_q == FAULT);
    assign bus.shutdown        = (state_q == SHUTDOWN);
    assign bus.active_fault_id = id_q;
    assign bus.cnt_uv          = cnt_uv;
    assign bus.cnt_ov          = cnt_ov;
    assign bus.cnt_ot          = cnt_ot;
    assign bus.cnt_uc          = cnt_uc;

endmodule : fault_fsm

// File: tb/tb_fault_fsm.sv
// -----------------------------------------------------------------------------
// tb_fault_fsm
//   Self-checking bench for fault_fsm: directed scenarios followed by
//   randomized segments, all compared against a behavioural model that works
//   on integer counters and an integer escalation level.
// -----------------------------------------------------------------------------
module tb_fault_fsm;
    import fault_fsm_pkg::*;

    localparam int CNT_W       = 8;
    localparam int WARN_TH     = 4;
    localparam int FAULT_TH    = 16;
    localparam int SHUTDOWN_TH = 32;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;
`ifdef FAULT_FSM_AUTO_RECOVER_EN
    localparam int AUTO_REC = 1;
`else
    localparam int AUTO_REC = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fault_fsm_if #(.CNT_W(CNT_W)) bus ();

    fault_fsm #(
        .CNT_W      (CNT_W),
        .WARN_TH    (WARN_TH),
        .FAULT_TH   (FAULT_TH),
        .SHUTDOWN_TH(SHUTDOWN_TH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus and model. Channel index c: 0 UV, 1 OV, 2 OT, 3 UC; id = c+1.
    logic flag [4];
    logic mask [4];
    logic clr;
    int   m_cnt [4];
    int   m_level;   // 0 normal, 1 warning, 2 fault, 3 shutdown
    int   m_id;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_edge();
        int order [4] = '{2, 1, 0, 3};   // OT > OV > UV > UC on ties
        int maxc = 0;
        int dom  = 0;
        if (rst) begin
            m_level = 0;
            m_id    = 0;
            for (int c = 0; c < 4; c++) m_cnt[c] = 0;
            return;
        end
        for (int k = 0; k < 4; k++) begin
            if (m_cnt[order[k]] > maxc) begin
                maxc = m_cnt[order[k]];
                dom  = order[k] + 1;
            end
        end
        if (m_level == 0) begin
            if (maxc >= WARN_TH) begin m_level = 1; m_id = dom; end
        end else if (m_level == 1) begin
            if (maxc >= FAULT_TH) begin m_level = 2; m_id = dom; end
            else if (clr && maxc < WARN_TH) begin m_level = 0; m_id = 0; end
            else if (AUTO_REC != 0 && maxc == 0) begin m_level = 0; m_id = 0; end
        end else if (m_level == 2) begin
            if (maxc >= SHUTDOWN_TH) begin m_level = 3; m_id = dom; end
            else if (clr && maxc == 0) begin m_level = 0; m_id = 0; end
        end
        for (int c = 0; c < 4; c++) begin
            if (flag[c] && !mask[c]) m_cnt[c] = (m_cnt[c] < CNT_MAX) ? m_cnt[c] + 1 : CNT_MAX;
            else                     m_cnt[c] = 0;
        end
    endfunction

    task automatic compare_all();
        check("state",    32'(bus.state),           m_level);
        check("warn",     32'(bus.warn),            32'(m_level == 1));
        check("fault",    32'(bus.fault),           32'(m_level == 2));
        check("shutdown", 32'(bus.shutdown),        32'(m_level == 3));
        check("fault_id", 32'(bus.active_fault_id), m_id);
        check("cnt_uv",   32'(bus.cnt_uv),          m_cnt[0]);
        check("cnt_ov",   32'(bus.cnt_ov),          m_cnt[1]);
        check("cnt_ot",   32'(bus.cnt_ot),          m_cnt[2]);
        check("cnt_uc",   32'(bus.cnt_uc),          m_cnt[3]);
    endtask

    // One clock edge: drive inputs, let the edge happen, advance the model,
    // then compare 1 time unit later.
    task automatic tick();
        bus.uv = flag[0]; bus.ov = flag[1]; bus.ot = flag[2]; bus.uc = flag[3];
        bus.mask_uv = mask[0]; bus.mask_ov = mask[1];
        bus.mask_ot = mask[2]; bus.mask_uc = mask[3];
        bus.clear_warning = clr;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic clear_inputs();
        for (int c = 0; c < 4; c++) begin
            flag[c] = 1'b0;
            mask[c] = 1'b0;
        end
        clr = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        clear_inputs();
        do_reset();
        check("rst_state", 32'(bus.state),           0);
        check("rst_id",    32'(bus.active_fault_id), 0);
        check("rst_flags", {29'd0, bus.warn, bus.fault, bus.shutdown}, 0);

        // 1: single-cycle UC glitch
        flag[3] = 1'b1; tick();
        check("s1_cnt_uc_1", 32'(bus.cnt_uc), 1);
        flag[3] = 1'b0; tick();
        check("s1_cnt_uc_0", 32'(bus.cnt_uc), 0);
        check("s1_state",    32'(bus.state),  0);
        check("s1_id",       32'(bus.active_fault_id), 0);

        // 2: OV for 20 edges, then acknowledge
        do_reset();
        flag[1] = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e == 4)  check("s2_e4_normal",   32'(bus.state), 0);
            if (e == 5)  check("s2_e5_warning",  32'(bus.state), 1);
            if (e == 5)  check("s2_e5_id",       32'(bus.active_fault_id), 2);
            if (e == 16) check("s2_e16_warning", 32'(bus.state), 1);
            if (e == 17) check("s2_e17_fault",   32'(bus.state), 2);
        end
        flag[1] = 1'b0; clr = 1'b1;
        tick(); tick();
        clr = 1'b0;
        check("s2_back_normal", 32'(bus.state), 0);
        check("s2_id_cleared",  32'(bus.active_fault_id), 0);

        // 3: UC for 40 edges, SHUTDOWN latches
        do_reset();
        flag[3] = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (e == 32) check("s3_e32_fault",    32'(bus.state), 2);
            if (e == 33) check("s3_e33_shutdown", 32'(bus.state), 3);
            if (e == 33) check("s3_e33_id",       32'(bus.active_fault_id), 4);
        end
        flag[3] = 1'b0; clr = 1'b1;
        for (int e = 0; e < 5; e++) tick();
        clr = 1'b0;
        check("s3_latched", 32'(bus.state), 3);
        do_reset();
        check("s3_rst_exit", 32'(bus.state), 0);

        // 4: masked channel never counts
        do_reset();
        mask[3] = 1'b1; flag[3] = 1'b1;
        for (int e = 0; e < 20; e++) tick();
        check("s4_cnt_uc", 32'(bus.cnt_uc), 0);
        check("s4_state",  32'(bus.state),  0);

        // Masking mid-count zeroes the counter on the next edge
        do_reset();
        flag[0] = 1'b1;
        tick(); tick(); tick();
        check("mask_mid_pre", 32'(bus.cnt_uv), 3);
        mask[0] = 1'b1; tick();
        check("mask_mid_post", 32'(bus.cnt_uv), 0);

        // 5: OT and OV tie -> OT wins
        do_reset();
        flag[1] = 1'b1; flag[2] = 1'b1;
        for (int e = 0; e < 6; e++) tick();
        check("s5_warning", 32'(bus.state), 1);
        check("s5_tie_id",  32'(bus.active_fault_id), 3);

        // WARNING with all counters zero and no acknowledge
        flag[1] = 1'b0; flag[2] = 1'b0;
        tick(); tick(); tick();
        check("warn_no_clr", 32'(bus.state), (AUTO_REC != 0) ? 0 : 1);

        // Escalation beats acknowledge in the same cycle
        do_reset();
        flag[0] = 1'b1; clr = 1'b1;
        for (int e = 0; e < 17; e++) tick();
        check("esc_over_clr", 32'(bus.state), 2);
        check("esc_id",       32'(bus.active_fault_id), 1);

        // 6: saturation
        do_reset();
        flag[1] = 1'b1;
        for (int e = 0; e < 300; e++) tick();
        check("s6_sat", 32'(bus.cnt_ov), CNT_MAX);
        check("s6_shutdown", 32'(bus.state), 3);

        // Randomized segments
        for (int seg = 0; seg < 40; seg++) begin
            int hot;
            int len;
            do_reset();
            hot = int'($urandom_range(0, 3));
            len = int'($urandom_range(20, 150));
            for (int e = 0; e < len; e++) begin
                for (int c = 0; c < 4; c++) begin
                    if (c == hot) flag[c] = ($urandom_range(0, 99) < 95);
                    else          flag[c] = ($urandom_range(0, 99) < 30);
                    if ($urandom_range(0, 99) < 3) mask[c] = ~mask[c];
                end
                if ($urandom_range(0, 99) < 8) hot = int'($urandom_range(0, 3));
                clr = ($urandom_range(0, 99) < 15);
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fault_fsm
